// File: rtl/mmio_pkg.sv
// Shared MMIO bus types and the peripheral register map, common to the initiator and the responder.
package mmio_pkg;

  localparam int MMIO_ADDR_WIDTH = 32;
  localparam int MMIO_DATA_WIDTH = 32;

  localparam logic WRITE_MODE = 1'b1;
  localparam logic READ_MODE  = 1'b0;

  localparam logic [31:0] DISPLAY_CONTROL   = 32'h20;
  localparam logic [31:0] TIMER_CONTROL     = 32'h21;
  localparam logic [31:0] TIMER_RELOAD      = 32'h22;
  localparam logic [31:0] UART_CONTROL      = 32'h23;
  localparam logic [31:0] UART_BAUD         = 32'h24;
  localparam logic [31:0] GPIO_CONTROL      = 32'h25;
  localparam logic [31:0] PERIPHERAL_STATUS = 32'h26;

  typedef struct packed {
    logic                       write;
    logic [MMIO_ADDR_WIDTH-1:0] address;
    logic [MMIO_DATA_WIDTH-1:0] data;
  } mmio_request_t;

endpackage

// File: rtl/mmio_request_fifo.sv
// In-order request queue; pointers carry an extra wrap bit so full and empty fall out of a compare.
module mmio_request_fifo
  import mmio_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  mmio_request_t push_data,
  input  logic          pop,
  output mmio_request_t head,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]   wr_ptr, rd_ptr;
  mmio_request_t mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head  = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full) mem[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mmio_bus_initiator.sv
// MMIO bus initiator: queues core requests, issues them one per cycle in order onto registered bus
// outputs, and captures read data into a single-entry response register.
module mmio_bus_initiator
  import mmio_pkg::*;
#(
  parameter int                    FIFO_DEPTH   = 4,
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] IDLE_ADDRESS = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] address_out,
  output logic                  mode_out,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  busy,
  output logic [15:0]           issued_count
);

  mmio_request_t push_req, head;
  logic          full, empty, issue, bus_active, bus_read, head_write;

  assign push_req = '{write:   req_write,
                      address: MMIO_ADDR_WIDTH'(req_address),
                      data:    MMIO_DATA_WIDTH'(req_data)};

  assign req_ready  = !full && !reset;
  assign head_write = (head.write == WRITE_MODE);

  mmio_request_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (req_valid && req_ready),
    .push_data (push_req),
    .pop       (issue),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // A read may only go out when the response register is guaranteed free by the end of its bus cycle.
  always_comb begin
    issue = 1'b0;
    if (!empty)
      issue = head_write || (!bus_read && (!rsp_valid || rsp_ready));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      address_out  <= IDLE_ADDRESS;
      mode_out     <= READ_MODE;
      data_out     <= '0;
      bus_active   <= 1'b0;
      bus_read     <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      issued_count <= '0;
    end else begin
      address_out  <= issue ? ADDR_WIDTH'(head.address) : IDLE_ADDRESS;
      mode_out     <= (issue && head_write) ? WRITE_MODE : READ_MODE;
      data_out     <= (issue && head_write) ? DATA_WIDTH'(head.data) : '0;
      bus_active   <= issue;
      bus_read     <= issue && !head_write;
      issued_count <= issued_count + 16'(issue);
      if (bus_read) begin
        rsp_valid <= 1'b1;
        rsp_data  <= data_in;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  assign busy = !empty || bus_active || rsp_valid;

endmodule

// File: tb/tb_mmio_bus_initiator.sv
// Scoreboard bench: a request-order reference model predicts bus cycles and read data; a monitor compares.
module tb_mmio_bus_initiator;
  import mmio_pkg::*;

  localparam int FIFO_DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic        req_ready;
  logic [31:0] req_address = '0, req_data = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_data, address_out, data_out, data_in;
  logic        mode_out, busy;
  logic [15:0] issued_count;

  mmio_bus_initiator #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .address_out(address_out), .mode_out(mode_out), .data_out(data_out),
    .data_in(data_in), .busy(busy), .issued_count(issued_count)
  );

  always #5 clock = ~clock;

  typedef struct { logic w; logic [31:0] a; logic [31:0] d; } bus_t;
  bus_t        exp_bus [$];
  logic [31:0] exp_rsp [$];
  bus_t        e;
  int          checks = 0, failures = 0, n_acc = 0;
  logic [31:0] mmem [256];
  bit          mvalid [256];
  bit          rand_rdy = 0, rdy_val = 0, hold_pend = 0;
  logic [31:0] held;

  // Unwritten registers read back a fixed per-address pattern; status reads 0x1234.
  function automatic logic [31:0] dflt(input logic [7:0] a);
    return (a == 8'h26) ? 32'h0000_1234 : {a, ~a, 8'hA5, a};
  endfunction

  // Responder: latches writes at the end of the bus cycle, drives read data combinationally.
  logic [31:0] rmem [256];
  logic        rwritten [256];
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) rwritten[i] <= 1'b0;
    end else if (mode_out) begin
      rmem[address_out[7:0]]     <= data_out;
      rwritten[address_out[7:0]] <= 1'b1;
    end
  end
  assign data_in = rwritten[address_out[7:0]] ? rmem[address_out[7:0]] : dflt(address_out[7:0]);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) mvalid[i] = 0;
    exp_bus.delete();
    exp_rsp.delete();
    n_acc = 0;
  endtask

  // In-order semantics: a read returns the last earlier write to its address.
  task automatic model_accept(input logic w, input logic [31:0] a, input logic [31:0] d);
    n_acc++;
    if (w) begin
      mmem[a[7:0]] = d;
      mvalid[a[7:0]] = 1;
      exp_bus.push_back('{1'b1, a, d});
    end else begin
      exp_bus.push_back('{1'b0, a, 32'h0});
      exp_rsp.push_back(mvalid[a[7:0]] ? mmem[a[7:0]] : dflt(a[7:0]));
    end
  endtask

  task automatic offer(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input int max_wait, output bit ok);
    req_valid = 1'b1; req_write = w; req_address = a; req_data = d; ok = 0;
    for (int i = 0; i < max_wait && !ok; i++) begin
      @(negedge clock);
      if (req_ready) ok = 1;
      @(posedge clock);
    end
    if (ok) model_accept(w, a, d);
    #1;
    req_valid = 1'b0; req_write = 1'b0; req_address = '0; req_data = '0;
  endtask

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d);
    bit ok;
    offer(w, a, d, 100, ok);
    chk("req_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_rsp_valid();
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (rsp_valid) seen = 1;
    end
    chk("rsp_valid_wait", 32'(seen), 32'd1);
    @(posedge clock); #1;
  endtask

  task automatic drain();
    bit done = 0;
    rand_rdy = 0; rdy_val = 1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clock);
      if (!busy && exp_bus.size() == 0 && exp_rsp.size() == 0) done = 1;
    end
    chk("drain_done", 32'(done), 32'd1);
    chk("issued_count", 32'(issued_count), 32'(16'(n_acc)));
    @(posedge clock); #1;
  endtask

  initial begin
    forever begin
      @(posedge clock); #1;
      rsp_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_val;
    end
  end

  // Monitor: every non-idle bus cycle and every response handshake is matched against the model.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        hold_pend = 0;
      end else begin
        if (hold_pend) begin
          chk("rsp_hold_valid", 32'(rsp_valid), 32'd1);
          chk("rsp_hold_data", rsp_data, held);
        end
        if (mode_out || address_out != 32'h0) begin
          if (exp_bus.size() == 0) begin
            checks++; failures++;
            $display("FAIL bus_unexpected actual=addr %h mode %0d expected=idle", address_out, mode_out);
          end else begin
            e = exp_bus.pop_front();
            chk("bus_mode", 32'(mode_out), 32'(e.w));
            chk("bus_addr", address_out, e.a);
            if (e.w) chk("bus_data", data_out, e.d);
          end
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_rsp.size() == 0) begin
            checks++; failures++;
            $display("FAIL rsp_unexpected actual=%h expected=none", rsp_data);
          end else begin
            chk("rsp_data", rsp_data, exp_rsp.pop_front());
          end
        end
        hold_pend = rsp_valid && !rsp_ready;
        held = rsp_data;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok, found;
    int cnt, base;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_address", address_out, 32'h0);
    chk("rst_mode", 32'(mode_out), 32'd0);
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_issued", 32'(issued_count), 32'd0);
    @(negedge clock); reset = 1'b0; #1;
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clock); #1;

    // Single write, then status read.
    send(1'b1, UART_CONTROL, 32'h0000_00A5);
    drain();
    send(1'b0, PERIPHERAL_STATUS, 32'h0);
    drain();

    // Two reads and a write with the response held: second read and write must wait.
    rdy_val = 0; wait_cycles(2);
    base = n_acc;
    send(1'b0, UART_BAUD, 32'h0);
    send(1'b0, GPIO_CONTROL, 32'h0);
    send(1'b1, DISPLAY_CONTROL, 32'h0000_0F0F);
    wait_cycles(8);
    chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("stall_issued", 32'(issued_count), 32'(base + 1));
    drain();

    // Queue fill behind a stalled read.
    rdy_val = 0; wait_cycles(2);
    send(1'b0, PERIPHERAL_STATUS, 32'h0);
    wait_rsp_valid();
    send(1'b0, TIMER_RELOAD, 32'h0);
    wait_cycles(2);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      offer(1'b1, 32'h30 + 32'(k), 32'h100 + 32'(k), 2, ok);
      if (ok) cnt++;
    end
    chk("full_accepts", 32'(cnt), 32'(FIFO_DEPTH - 1));
    chk("full_req_ready", 32'(req_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    drain();

    // Write then read the same register.
    send(1'b1, TIMER_CONTROL, 32'hDEAD_BEEF);
    send(1'b0, TIMER_CONTROL, 32'h0);
    drain();

    // Randomized traffic with random response back-pressure.
    rand_rdy = 1;
    for (int n = 0; n < 150; n++) begin
      logic [31:0] a, d;
      logic w;
      w = 1'($urandom_range(0, 1));
      a = $urandom_range(1, 255) | ($urandom_range(0, 1) << 16);
      d = $urandom;
      send(w, a, d);
      if ($urandom_range(0, 3) == 0) wait_cycles($urandom_range(1, 3));
    end
    drain();

    // Reset in the middle of a bus write with requests still queued.
    rdy_val = 0; wait_cycles(2);
    send(1'b0, PERIPHERAL_STATUS, 32'h0);
    wait_rsp_valid();
    send(1'b0, GPIO_CONTROL, 32'h0);
    send(1'b1, TIMER_CONTROL, 32'h1111_1111);
    send(1'b1, TIMER_RELOAD, 32'h2222_2222);
    send(1'b1, UART_CONTROL, 32'h3333_3333);
    rdy_val = 1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      if (mode_out) found = 1;
    end
    chk("mid_write_seen", 32'(found), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_address", address_out, 32'h0);
    chk("mid_rst_mode", 32'(mode_out), 32'd0);
    chk("mid_rst_data_out", data_out, 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_issued", 32'(issued_count), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 1'b0;
    wait_cycles(10);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_issued", 32'(issued_count), 32'd0);
    send(1'b1, UART_BAUD, 32'h0000_A5A5);
    send(1'b0, UART_BAUD, 32'h0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
